// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and increment for the pointer
// controllers on both sides of the asynchronous FIFO, plus default widths.
package fifo_pkg;

    localparam int PTR_W  = 3;
    localparam int DATA_W = 8;

    // Callers pass the pointer width; values are carried in 32 bits.
    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        logic [31:0] bm;
        bm = b & width_mask(w);
        return bm ^ (bm >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] gm;
        logic [31:0] b;
        gm = g & width_mask(w);
        b  = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    function automatic logic [31:0] gray_inc(input logic [31:0] g, input int w);
        return bin2gray((gray2bin(g, w) + 32'd1) & width_mask(w), w);
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// Shared by the read and write controllers; STAGES must be 2 or more.
module ptr_sync #(
    parameter int W      = 3,
    parameter int STAGES = 2
) (
    input  logic         clkin,
    input  logic         rstin,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/read_ctrl.sv
// Read-side pointer controller of the async FIFO: tail sync, empty detect,
// registered valid/ready output stage. Optional level output: READ_CTRL_LEVEL_EN.
module read_ctrl #(
    parameter int PTR_W       = fifo_pkg::PTR_W,
    parameter int DATA_W      = fifo_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clkout,
    input  logic              rstout,
    input  logic [PTR_W-1:0]  tail_i,
    output logic [PTR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    input  logic              oready,
    output logic [PTR_W-1:0]  head,
    output logic              empty
`ifdef READ_CTRL_LEVEL_EN
    ,
    output logic [PTR_W-1:0]  level
`endif
);

    logic [PTR_W-1:0] tail_s;
    logic [PTR_W-1:0] head_nxt;
    logic             free;
    logic             load;

    ptr_sync #(
        .W      (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_tail_sync (
        .clkin (clkout),
        .rstin (rstout),
        .d     (tail_i),
        .q     (tail_s)
    );

    assign empty    = (head == tail_s);
    assign free     = !ovalid || oready;
    assign load     = free && !empty;
    assign rd_addr  = head;
    assign head_nxt = PTR_W'(fifo_pkg::gray_inc(32'(head), PTR_W));

    // head only moves when a word is captured, so the writer never reclaims
    // a slot whose data is still unread.
    always_ff @(posedge clkout or posedge rstout) begin
        if (rstout) begin
            head   <= '0;
            odata  <= '0;
            ovalid <= 1'b0;
        end else if (load) begin
            head   <= head_nxt;
            odata  <= rd_data;
            ovalid <= 1'b1;
        end else if (free) begin
            ovalid <= 1'b0;
        end
    end

`ifdef READ_CTRL_LEVEL_EN
    always_ff @(posedge clkout or posedge rstout) begin
        if (rstout) begin
            level <= '0;
        end else begin
            level <= PTR_W'(fifo_pkg::gray2bin(32'(tail_s), PTR_W)
                          - fifo_pkg::gray2bin(32'(head), PTR_W));
        end
    end
`endif

endmodule
